// File: rtl/lsu_subword_rmw.sv
// Load/store unit that turns RISC-V byte/half/word accesses into word accesses with RMW stores.
// Optional LSU_PERF_CNT_EN adds load/store/error completion counters.
module lsu_subword_rmw #(
    parameter int unsigned MEM_WORDS = 256
`ifdef LSU_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [2:0]       req_funct3_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    output logic             resp_valid_o,
    output logic [31:0]      resp_rdata_o,
    output logic             resp_err_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] ld_cnt_o,
    output logic [CNT_W-1:0] st_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
`endif
);

    localparam logic [32:0] AddrLimit = 33'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e      state_q, state_d;
    logic        we_q, err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, merge_q, rdata_q;

    logic        accept, req_err;
    logic [31:0] load_data, merged;

    assign accept = req_valid_i && (state_q == StIdle);

    always_comb begin
        logic misal, illegal, oor;
        misal   = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                  (req_funct3_i == 3'b010 && req_addr_i[1:0] != 2'b00);
        illegal = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                  (req_we_i && req_funct3_i[2]);
        oor     = {1'b0, req_addr_i} >= AddrLimit;
        req_err = misal || illegal || oor;
    end

    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
            3'b010:  load_data = mem_rdata_i;
            3'b100:  load_data = {24'b0, lane_b};
            3'b101:  load_data = {16'b0, lane_h};
            default: load_data = 32'b0;
        endcase
        merged = mem_rdata_i;
        if (!funct3_q[0]) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else              merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err)                      state_d = StDone;
                    else if (!req_we_i)               state_d = StRd;
                    else if (req_funct3_i == 3'b010)  state_d = StWr;
                    else                              state_d = StRd;
                end
            end
            StRd:    state_d = we_q ? StWr : StDone;
            StWr:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready_o  = (state_q == StIdle);
        mem_re_o     = (state_q == StRd);
        mem_we_o     = (state_q == StWr);
        resp_valid_o = (state_q == StDone);
        resp_err_o   = (state_q == StDone) && err_q;
        resp_rdata_o = rdata_q;
        mem_addr_o   = {addr_q[31:2], 2'b00};
        mem_wdata_o  = (funct3_q == 3'b010) ? wdata_q : merge_q;
    end

    // Load result and RMW merge word are both captured from the single RD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            merge_q  <= 32'b0;
            rdata_q  <= 32'b0;
        end else if (accept) begin
            we_q     <= req_we_i;
            err_q    <= req_err;
            funct3_q <= req_funct3_i;
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            rdata_q  <= 32'b0;
        end else if (state_q == StRd) begin
            if (we_q) merge_q <= merged;
            else      rdata_q <= load_data;
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_o  <= '0;
            st_cnt_o  <= '0;
            err_cnt_o <= '0;
        end else if (state_q == StDone) begin
            if (err_q)      err_cnt_o <= err_cnt_o + 1'b1;
            else if (we_q)  st_cnt_o  <= st_cnt_o + 1'b1;
            else            ld_cnt_o  <= ld_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Directed self-checking bench for lsu_subword_rmw with a 256-word behavioural DMEM.
module tb_lsu_subword_rmw;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic        resp_valid, resp_err, mem_re, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef LSU_PERF_CNT_EN
    logic [1:0]  ld_cnt, st_cnt, err_cnt;
`endif

    logic [31:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_waddr = 8'b0;
    logic [31:0] tb_wdata = 32'b0;

    int n_checks = 0, n_pass = 0, excl_bad = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr[9:2]] <= mem_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    lsu_subword_rmw #(
        .MEM_WORDS(256)
`ifdef LSU_PERF_CNT_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_we_i(req_we),
        .req_funct3_i(req_funct3),
        .req_addr_i(req_addr),
        .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid),
        .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err),
        .mem_re_o(mem_re),
        .mem_we_o(mem_we),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
`ifdef LSU_PERF_CNT_EN
        ,
        .ld_cnt_o(ld_cnt),
        .st_cnt_o(st_cnt),
        .err_cnt_o(err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic poke(input logic [7:0] widx, input logic [31:0] data);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = widx; tb_wdata = data;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic err, output int nre, output int nwe,
                          output logic [31:0] wword);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; rd = 32'hxxxx_xxxx; err = 1'bx; nre = 0; nwe = 0; wword = 32'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_re && mem_we) excl_bad++;
            if (mem_re) nre++;
            if (mem_we) begin nwe++; wword = mem_wdata; end
            if (resp_valid) begin
                lat = k; rd = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic expect_req(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                              input int exp_re, input int exp_we);
        int lat, nre, nwe;
        logic [31:0] rd, wword;
        logic err;
        do_req(we, f3, addr, wd, lat, rd, err, nre, nwe, wword);
        check({name, "_rdata"}, rd, exp_rd);
        check({name, "_err"}, {31'b0, err}, {31'b0, exp_err});
        check({name, "_lat"}, lat, exp_lat);
        check({name, "_re"}, nre, exp_re);
        check({name, "_we"}, nwe, exp_we);
    endtask

    initial begin
        int lat, nre, nwe, nresp;
        logic [31:0] rd, wword;
        logic err;

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_strobes", {30'b0, mem_re, mem_we}, 32'd0);
        rst_n = 1'b1;

        poke(8'd4, 32'h8000_80F0);
        poke(8'd2, 32'h1122_3344);

        expect_req("lb",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 1, 0);
        expect_req("lbu", 1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 0);
        expect_req("lh",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0, 2, 1, 0);
        expect_req("lhu", 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_8000, 1'b0, 2, 1, 0);
        expect_req("lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'h8000_80F0, 1'b0, 2, 1, 0);

        do_req(1'b1, 3'b000, 32'h09, 32'h0000_00AB, lat, rd, err, nre, nwe, wword);
        check("sb_lat", lat, 3);
        check("sb_re", nre, 1);
        check("sb_we", nwe, 1);
        check("sb_wdata", wword, 32'h1122_AB44);
        check("sb_rdata", rd, 32'h0);
        check("sb_mem", mem[2], 32'h1122_AB44);

        poke(8'd2, 32'h1122_3344);
        expect_req("sh", 1'b1, 3'b001, 32'h0A, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 1);
        check("sh_mem", mem[2], 32'hBEEF_3344);
        expect_req("sw", 1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1);
        check("sw_mem", mem[3], 32'hDEAD_BEEF);

        expect_req("lw_mis",  1'b0, 3'b010, 32'h06,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        expect_req("lh_mis",  1'b0, 3'b001, 32'h03,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        expect_req("sb_f100", 1'b1, 3'b100, 32'h00,  32'hFF, 32'h0, 1'b1, 1, 0, 0);
        expect_req("lw_oor",  1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        expect_req("ld_f011", 1'b0, 3'b011, 32'h10,  32'h0, 32'h0, 1'b1, 1, 0, 0);
        check("sh_mem_after_err", mem[2], 32'hBEEF_3344);

        // Abort an SB while in its read phase.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h08;
        req_wdata = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_rd", {31'b0, mem_re}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we_low", {31'b0, mem_we}, 32'd0);
        nwe = 0; nresp = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (resp_valid) nresp++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (resp_valid) nresp++;
        end
        check("abort_no_we", nwe, 0);
        check("abort_no_resp", nresp, 0);
        check("abort_mem", mem[2], 32'hBEEF_3344);
        check("abort_ready", {31'b0, req_ready}, 32'd1);

`ifdef LSU_PERF_CNT_EN
        for (int i = 0; i < 5; i++)
            do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, err, nre, nwe, wword);
        do_req(1'b1, 3'b010, 32'h0C, 32'h1234_5678, lat, rd, err, nre, nwe, wword);
        do_req(1'b0, 3'b010, 32'h06, 32'h0, lat, rd, err, nre, nwe, wword);
        @(negedge clk);
        check("ld_cnt_wrap", {30'b0, ld_cnt}, 32'd1);
        check("st_cnt", {30'b0, st_cnt}, 32'd1);
        check("err_cnt", {30'b0, err_cnt}, 32'd1);
`endif

        // A request held high while busy must be taken only once.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk);
        nre = 0; nresp = 0;
        @(negedge clk);
        check("held_busy_ready", {31'b0, req_ready}, 32'd0);
        if (mem_re) nre++;
        @(negedge clk);
        if (mem_re) nre++;
        if (resp_valid) nresp++;
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (mem_re) nre++;
            if (resp_valid) nresp++;
        end
        check("held_once_re", nre, 1);
        check("held_once_resp", nresp, 1);
        check("held_idle_ready", {31'b0, req_ready}, 32'd1);

        check("re_we_exclusive", excl_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_subword_rmw.md
Name: lsu_subword_rmw

Overview:
- Load/store unit between the pipeline MEM stage and the word-only data memory (256 x 32, combinational read, synchronous word write).
- Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Handles byte-lane selection and sign/zero extension on loads.
- Performs read-modify-write for sub-word stores and flags misaligned or out-of-range accesses.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; valid byte addresses are 0 to MEM_WORDS*4-1.
- CNT_W, 16, width of each performance counter (used only with LSU_PERF_CNT_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  access error, valid with resp_valid.
- mem_re  output  1  DMEM read enable.
- mem_we  output  1  DMEM write enable.
- mem_addr  output  32  word-aligned address with [1:0] forced to 00.
- mem_wdata  output  32  full word to write.
- mem_rdata  input  32  DMEM combinational read data.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset values: state IDLE; resp_valid 0, resp_rdata 0, resp_err 0; mem_re/mem_we 0; latched request registers 0.
- req_ready = (state == IDLE).
- Accept on req_valid & req_ready. Latch req_we, req_funct3, req_addr and req_wdata. Inputs are ignored while busy.
- Error check at accept; an error goes straight to DONE with no memory access.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0] != 00.
  - Illegal funct3: 011/110/111, or store with 100/101.
  - Out of range: addr >= MEM_WORDS*4.
- Normal path at accept:
  - Load → RD.
  - SW → WR.
  - SB/SH → RD.
- RD:
  - mem_re=1 and sample mem_rdata.
  - Load: select byte (addr[1:0]) or halfword (addr[1]), sign-extend (B/H) or zero-extend (BU/HU). Register into resp_rdata, then → DONE.
  - Sub-word store: merge req_wdata[7:0] or [15:0] into the selected lane of mem_rdata, store in merge register, then → WR.
- WR: mem_we=1; mem_wdata = merged word (SB/SH) or req_wdata (SW); → DONE.
- DONE: resp_valid=1 for exactly one cycle. resp_err as decided at accept; resp_rdata=0 for stores and errors. → IDLE.
- mem_re/mem_we/mem_addr/mem_wdata are decoded from state and latched registers only; never from live req_* inputs.
- mem_re and mem_we are never high together.
- Latency accept→resp_valid: load 2 cycles, SW 2, SB/SH 3, error 1. The next accept is possible the cycle after DONE.
- Reset mid-operation: state returns to IDLE asynchronously; mem_we drops immediately, so no partial RMW write completes; no resp_valid is issued for the aborted request.

Optional Feature:
- Macro LSU_PERF_CNT_EN.
- Defined:
  - Adds outputs ld_cnt, st_cnt, err_cnt, each CNT_W bits.
  - Each increments in DONE for its request class (errors count only in err_cnt).
  - Counters wrap 2^CNT_W-1 → 0 and clear on rst_n.
- Undefined: no counter ports or logic; behaviour otherwise identical.

Test Plan:
- DMEM word 4 = 0x8000_80F0. LB @0x10 → resp_rdata 0xFFFF_FFF0. LBU @0x11 → 0x0000_0080. LH @0x12 → 0xFFFF_8000. All with resp_err=0, latency 2.
- DMEM word 2 = 0x1122_3344. SB wdata 0xAB @0x09 → one mem_re cycle, then mem_we with mem_wdata 0x1122_AB44; resp_valid 3 cycles after accept.
- SH 0xBEEF @0x0A onto 0x1122_3344 → word 2 = 0xBEEF_3344. SW 0xDEAD_BEEF @0x0C → single mem_we, no mem_re.
- LW @0x06, LH @0x03, SB funct3=100, LW @0x400 (MEM_WORDS=256) → each: resp_err=1, resp_rdata=0, mem_re/mem_we never asserted, latency 1.
- Assert rst_n low during RD of an SB → mem_we never pulses; DMEM word unchanged; req_ready=1 after reset release. A request held while busy is accepted only once.
- With LSU_PERF_CNT_EN and CNT_W=2: 5 loads → ld_cnt=1 after wrap; 1 store → st_cnt=1; 1 error → err_cnt=1.
